dmem_wb_bridge: RTL

DMEM_WB_BRIDGE -- requirements
Module: dmem_wb_bridge

---
 rtl/dmem_bridge_pkg.sv | 68 ++++++
 rtl/dmem_wb_bridge.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge_pkg.sv
// Shared types and lane helpers for the core-data-memory to Wishbone bridge.
package dmem_bridge_pkg;

  // Access size encoding as presented by the core; 2'b11 is illegal.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } width_e;

  // Bridge sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  // True when the access cannot be served by a single aligned bus word.
  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    logic mis;
    case (width)
      BYTE:    mis = 1'b0;
      HALF:    mis = addr_lo[0];
      WORD:    mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

  // Byte-enable pattern for the addressed lane(s); reads enable nothing.
  function automatic logic [3:0] gen_strb(input logic we, input logic [1:0] width,
                                          input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (width)
      BYTE:    strb = 4'b0001 << addr_lo;
      HALF:    strb = 4'b0011 << addr_lo;
      default: strb = 4'b1111;
    endcase
    if (!we) strb = 4'b0000;
    return strb;
  endfunction

  // Copy LSB-justified write data into every lane it could land in.
  function automatic logic [31:0] replicate_wdata(input logic [1:0] width, input logic [31:0] wdata);
    logic [31:0] data;
    case (width)
      BYTE:    data = {4{wdata[7:0]}};
      HALF:    data = {2{wdata[15:0]}};
      default: data = wdata;
    endcase
    return data;
  endfunction

  // Pull the addressed lane(s) down to bit 0 and zero-extend.
  function automatic logic [31:0] extract_lane(input logic [31:0] data, input logic [1:0] width,
                                               input logic [1:0] addr_lo);
    logic [31:0] shifted;
    logic [31:0] res;
    shifted = data >> {addr_lo, 3'b000};
    case (width)
      BYTE:    res = {24'h0, shifted[7:0]};
      HALF:    res = {16'h0, shifted[15:0]};
      default: res = shifted;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_wb_bridge.sv
// Converts single core data-memory requests into one Wishbone word access,
// with misalignment rejection and an ack timeout. All outputs are flops.
// Handshake: the core holds dmem_req (and its fields) until dmem_resp, a
// one-cycle pulse; the bus side keeps wb_cyc/wb_stb high until wb_ack or timeout.
module dmem_wb_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_req,
  input  logic        dmem_cmd,
  input  logic [1:0]  dmem_width,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic        dmem_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_wstrb,
  output logic [31:0] wb_addr,
  output logic [31:0] wb_data_out,
  input  logic [31:0] wb_data_in,
  input  logic        wb_ack,
  output state_e      dbg_state
);

  // Counter only needs to reach TIMEOUT_CYCLES-1: the final no-ack cycle is
  // the one whose increment would hit TIMEOUT_CYCLES, so we leave instead.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cmd_q, cmd_d;
  logic [1:0]         width_q, width_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [3:0]         strb_q, strb_d;
  logic [31:0]        wb_addr_q, wb_addr_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               resp_q, resp_d;

  logic req_mis;
  logic timeout_hit;

  assign req_mis     = is_misaligned(dmem_width, dmem_addr[1:0]);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register; reset drops straight back to IDLE, abandoning any access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state: misaligned requests skip the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (dmem_req) state_d = req_mis ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (wb_ack || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values, so every output comes straight from a flop.
  always_comb begin
    cmd_d     = cmd_q;
    width_d   = width_q;
    addr_lo_d = addr_lo_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    strb_d    = strb_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    resp_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (dmem_req) begin
          cmd_d     = dmem_cmd;
          width_d   = dmem_width;
          addr_lo_d = dmem_addr[1:0];
          cnt_d     = '0;
          if (req_mis) begin
            resp_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            cyc_d     = 1'b1;
            we_d      = dmem_cmd;
            strb_d    = gen_strb(dmem_cmd, dmem_width, dmem_addr[1:0]);
            wb_addr_d = {dmem_addr[31:2], 2'b00};
            wb_data_d = replicate_wdata(dmem_width, dmem_wdata);
          end
        end
      end
      ST_ACCESS: begin
        if (wb_ack || timeout_hit) begin
          cyc_d     = 1'b0;
          we_d      = 1'b0;
          strb_d    = 4'b0000;
          wb_addr_d = '0;
          wb_data_d = '0;
          resp_d    = 1'b1;
          err_d     = !wb_ack;
          rdata_d   = (wb_ack && !cmd_q) ? extract_lane(wb_data_in, width_q, addr_lo_q) : '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      cmd_q     <= 1'b0;
      width_q   <= 2'b00;
      addr_lo_q <= 2'b00;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      strb_q    <= 4'b0000;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      width_q   <= width_d;
      addr_lo_q <= addr_lo_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      strb_q    <= strb_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
    end
  end

  assign wb_cyc      = cyc_q;
  assign wb_stb      = cyc_q;
  assign wb_we       = we_q;
  assign wb_wstrb    = strb_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data_out = wb_data_q;
  assign dmem_rdata  = rdata_q;
  assign dmem_err    = err_q;
  assign dmem_resp   = resp_q;
  assign dbg_state   = state_q;

endmodule
